// File: rtl/vj_sched_pkg.sv
// Shared definitions for the integral-image bank scheduler.
// Bank state encoding and II geometry used by both builder and scheduler.
package vj_sched_pkg;

  typedef enum logic [1:0] {
    BK_FREE = 2'd0,
    BK_FILL = 2'd1,
    BK_FULL = 2'd2,
    BK_SCAN = 2'd3
  } bank_st_e;

  localparam int II_W = 321;
  localparam int II_H = 241;
  localparam int II_INIT_CYCLES = II_W + II_H;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vj_ii_fill_timer.sv
// Fill timer: counts from builder start, opens the pixel gate after
// border init and flags a hung build.
module vj_ii_fill_timer
  import vj_sched_pkg::*;
#(
  parameter int INIT_CYCLES   = II_INIT_CYCLES,
  parameter int BUILD_TIMEOUT = 131072
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic stop_i,
  output logic init_done_o,
  output logic timeout_o
);

  localparam int TW = $clog2(max2(BUILD_TIMEOUT, INIT_CYCLES) + 1);
  localparam logic [TW-1:0] INIT_V = TW'(INIT_CYCLES);
  // Flagged one count early so the abort lands exactly at BUILD_TIMEOUT.
  localparam logic [TW-1:0] LAST_V = TW'(BUILD_TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (stop_i) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign init_done_o = run_q && (cnt_q >= INIT_V);
  assign timeout_o   = run_q && (cnt_q == LAST_V);

endmodule

// File: rtl/vj_ii_bank_scheduler.sv
// Ping-pong scheduler for the two integral-image banks: frame acceptance,
// pixel gating, detector dispatch, drop accounting and build watchdog.
module vj_ii_bank_scheduler
  import vj_sched_pkg::*;
#(
  parameter int INIT_CYCLES     = II_INIT_CYCLES,
  parameter int BUILD_TIMEOUT   = 131072,
  parameter bit OVERWRITE_STALE = 1'b1,
  parameter int DROP_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              cam_sof,
  output logic              cam_ready,
  output logic              builder_frame_start,
  input  logic              builder_done,
  output logic              wr_bank,
  output logic              det_start,
  output logic              det_bank,
  input  logic              det_done,
  output logic [3:0]        bank_state,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              timeout_err,
  input  logic              clear_status
);

  bank_st_e st_q [2];
  bank_st_e st_d [2];

  logic newest_q, newest_d;
  logic start_q, start_d;
  logic wr_bank_q, wr_bank_d;
  logic dstart_q, dstart_d;
  logic dbank_q, dbank_d;
  logic err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic       tmr_start, tmr_stop;
  logic       tmr_init, tmr_to;
  logic       has_fill, fill_b;
  logic       has_scan, scan_b;
  logic       pick, oth, fill_now, abort;
  logic [1:0] drop_n;
  logic [DROP_W:0] drop_sum;

  assign has_fill = (st_q[0] == BK_FILL) || (st_q[1] == BK_FILL);
  assign fill_b   = (st_q[1] == BK_FILL);
  assign has_scan = (st_q[0] == BK_SCAN) || (st_q[1] == BK_SCAN);
  assign scan_b   = (st_q[1] == BK_SCAN);

  vj_ii_fill_timer #(
    .INIT_CYCLES  (INIT_CYCLES),
    .BUILD_TIMEOUT(BUILD_TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (tmr_start),
    .stop_i     (tmr_stop),
    .init_done_o(tmr_init),
    .timeout_o  (tmr_to)
  );

  always_comb begin
    st_d[0]   = st_q[0];
    st_d[1]   = st_q[1];
    newest_d  = newest_q;
    start_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    dstart_d  = 1'b0;
    dbank_d   = dbank_q;
    tmr_start = 1'b0;
    tmr_stop  = 1'b0;
    abort     = 1'b0;
    drop_n    = 2'd0;
    pick      = 1'b0;
    oth       = 1'b0;
    fill_now  = 1'b0;

    if (has_fill && builder_done) begin
      st_d[fill_b] = BK_FULL;
      newest_d     = fill_b;
      tmr_stop     = 1'b1;
    end else if (has_fill && tmr_to) begin
      st_d[fill_b] = BK_FREE;
      tmr_stop     = 1'b1;
      abort        = 1'b1;
    end

    if (has_scan && det_done) begin
      st_d[scan_b] = BK_FREE;
    end

    // Dispatch decides on registered state; an older FULL bank is discarded.
    if (!has_scan &&
        ((st_q[0] == BK_FULL) || (st_q[1] == BK_FULL))) begin
      pick     = (st_q[newest_q] == BK_FULL) ? newest_q : ~newest_q;
      oth      = ~pick;
      st_d[pick] = BK_SCAN;
      dstart_d = 1'b1;
      dbank_d  = pick;
      if (st_q[oth] == BK_FULL) begin
        st_d[oth] = BK_FREE;
        drop_n    = drop_n + 2'd1;
      end
    end

    if (cam_sof) begin
      fill_now = (st_d[0] == BK_FILL) || (st_d[1] == BK_FILL);
      if (!enable || fill_now) begin
        drop_n = drop_n + 2'd1;
      end else if (st_d[0] == BK_FREE || st_d[1] == BK_FREE) begin
        pick       = (st_d[0] != BK_FREE);
        st_d[pick] = BK_FILL;
        start_d    = 1'b1;
        wr_bank_d  = pick;
        tmr_start  = 1'b1;
      end else if (OVERWRITE_STALE &&
                   (st_d[0] == BK_FULL || st_d[1] == BK_FULL)) begin
        pick       = (st_d[0] != BK_FULL);
        st_d[pick] = BK_FILL;
        start_d    = 1'b1;
        wr_bank_d  = pick;
        tmr_start  = 1'b1;
        drop_n     = drop_n + 2'd1;
      end else begin
        drop_n = drop_n + 2'd1;
      end
    end

    drop_sum = {1'b0, drop_q} + {{(DROP_W-1){1'b0}}, drop_n};
    if (clear_status) begin
      drop_d = '0;
      err_d  = 1'b0;
    end else begin
      drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      err_d  = err_q | abort;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q[0]   <= BK_FREE;
      st_q[1]   <= BK_FREE;
      newest_q  <= 1'b0;
      start_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      dstart_q  <= 1'b0;
      dbank_q   <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      st_q[0]   <= st_d[0];
      st_q[1]   <= st_d[1];
      newest_q  <= newest_d;
      start_q   <= start_d;
      wr_bank_q <= wr_bank_d;
      dstart_q  <= dstart_d;
      dbank_q   <= dbank_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign cam_ready           = tmr_init;
  assign builder_frame_start = start_q;
  assign wr_bank             = wr_bank_q;
  assign det_start           = dstart_q;
  assign det_bank            = dbank_q;
  assign bank_state          = {st_q[1], st_q[0]};
  assign drop_cnt            = drop_q;
  assign timeout_err         = err_q;

endmodule

// File: doc/vj_ii_bank_scheduler.md
# vj_ii_bank_scheduler

Ping-pong scheduler for the two integral-image banks in the Viola-Jones pipeline. It accepts camera start-of-frame events and starts the integral builder on a free bank. It gates pixels until the builder's border-init phase is over, then hands completed banks to the Haar cascade detector. Tracks per-bank ownership, drops frames when no bank is available, and recovers from a hung build via a watchdog.

## Interface
- `INIT_CYCLES`, 562 — builder border-init length (II_W + II_H); pixel gate opens after this.
- `BUILD_TIMEOUT`, 131072 — max cycles from builder start to `builder_done` before abort.
- `OVERWRITE_STALE`, 1 — when 1, a FULL bank not being scanned may be reclaimed for a new frame.
- `DROP_W`, 16 — width of the dropped-frame counter.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new frame is accepted; work in progress completes.
- `cam_sof`  in  1  one-cycle start-of-frame pulse from the pixel source.
- `cam_ready`  out  1  pixel gate; the pixel source's `pixel_valid` is ANDed with this before it reaches the builder.
- `builder_frame_start`  out  1  one-cycle start pulse to the integral builder.
- `builder_done`  in  1  builder's one-cycle build-complete pulse.
- `wr_bank`  out  1  bank the builder writes; stable while a fill is active.
- `det_start`  out  1  one-cycle scan-start pulse to the detector.
- `det_bank`  out  1  bank the detector reads; stable while a scan is active.
- `det_done`  in  1  detector's one-cycle scan-complete pulse.
- `bank_state`  out  4  {bank1, bank0} 2-bit states, for status only.
- `drop_cnt`  out  DROP_W  saturating count of dropped frames.
- `timeout_err`  out  1  sticky flag, set by a watchdog abort.
- `clear_status`  in  1  clears `drop_cnt` and `timeout_err`.

## Operation
- Each bank has a state: FREE=0, FILL=1, FULL=2, SCAN=3. At most one bank is in FILL and at most one in SCAN.
- A register `newest` records the bank that most recently entered FULL.
- Per-cycle update order:
  1. `builder_done` moves the FILL bank to FULL and updates `newest`.
  2. `det_done` moves the SCAN bank to FREE.
  3. `cam_sof` is evaluated against the updated states.
- Frame acceptance, on `cam_sof` with `enable` high and no bank in FILL:
  - A FREE bank (lowest index first) goes to FILL.
  - Otherwise, if `OVERWRITE_STALE` is 1 and a FULL bank exists, that bank goes to FILL and counts as a drop.
  - Otherwise the frame is dropped and `drop_cnt` increments.
- `cam_sof` while a fill is active, or while `enable` is low, is always a drop. `cam_ready` stays low for a dropped frame.
- Fill sequence:
  - `builder_frame_start` pulses and `wr_bank` is set.
  - The fill timer counts from 0. `cam_ready` goes high when the timer reaches `INIT_CYCLES`.
  - `cam_ready` falls on `builder_done`.
- Watchdog: if the timer reaches `BUILD_TIMEOUT` with no `builder_done`, the FILL bank goes to FREE, `cam_ready` drops, and `timeout_err` sets. The builder is not reset; the next accepted frame's start pulse reinitializes it.
- Dispatch: when no bank is in SCAN and a FULL bank exists, the bank selected by `newest` goes to SCAN and `det_bank` is set. If the other bank is also FULL, it goes to FREE in the same cycle and counts as a drop.
- `det_done` or `builder_done` with no matching SCAN/FILL bank is ignored.
- `drop_cnt` saturates at all ones. When `clear_status` coincides with an increment, clear wins.

## Timing
- Reset value of every output is 0. Both banks start FREE, `newest`=0, timer=0.
- `cam_sof` at cycle t (accepted): `builder_frame_start` and `wr_bank` valid at t+1; `cam_ready` high from t+1+`INIT_CYCLES`.
- `builder_done` at t: bank FULL at t+1, `cam_ready` low at t+1. If the detector is idle, `det_start` pulses at t+2.
- `det_done` at t: bank FREE at t+1. A `cam_sof` at t may already claim that bank.
- `builder_done` and `cam_sof` in the same cycle: the sof is accepted only if a FREE bank (or a stale FULL bank) remains after the done update.
- `enable` falling mid-fill or mid-scan: the operation completes normally.
- `reset_n` asserted mid-operation: everything returns to reset values immediately, with no pending pulses.

## Structure
- Package `vj_sched_pkg`:
  - bank state encoding (FREE/FILL/FULL/SCAN);
  - `INIT_CYCLES` default derived from II_W/II_H (321, 241);
  - II geometry constants shared with the builder.
- Sub-module `vj_ii_fill_timer`:
  - counter with start/stop;
  - init-done output (gate open);
  - timeout output.
- The top level holds the bank states, acceptance, dispatch and status logic.

## Test plan
- Single frame: reset, `cam_sof` at cycle 10, then `builder_done` at 10+1+562+76800.
  - `builder_frame_start`@11, `wr_bank`=0.
  - `cam_ready` high 573 through `builder_done`.
  - `det_start`@done+2, `det_bank`=0.
- Ping-pong: second `cam_sof` during the scan of bank 0 → fills bank 1. `det_done` then a further sof → bank 0 reused, `drop_cnt`=0.
- Overflow, `OVERWRITE_STALE`=1: detector stalled, banks SCAN/FULL, new sof → FULL bank refilled, `drop_cnt`=1.
  - Same with `OVERWRITE_STALE`=0 → frame dropped, `cam_ready` stays 0, `drop_cnt`=1.
- Watchdog: `BUILD_TIMEOUT`=1000, no `builder_done` → bank FREE at start+1000, `timeout_err`=1. `clear_status` → 0.
- Simultaneous events:
  - `det_done` and `cam_sof` in the same cycle with both banks busy → sof accepted into the freed bank.
  - `reset_n` pulse mid-fill → all outputs 0 and `bank_state`=0 at once.
